urv_timer_cmp: RTL and testbench



---
 rtl/urv_defs.sv | 23 ++
 rtl/urv_timer_cmp.sv | 141 ++++++++++++++
 tb/tb_urv_timer_cmp.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/urv_defs.sv
// Shared definitions for the timer compare unit: register map, CTRL/STATUS
// bit positions and the timer width.
package urv_defs;

  localparam int unsigned TIMER_W = 40;

  localparam logic [2:0] REG_TIME_LO = 3'd0;
  localparam logic [2:0] REG_TIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO  = 3'd2;
  localparam logic [2:0] REG_CMP_HI  = 3'd3;
  localparam logic [2:0] REG_PERIOD  = 3'd4;
  localparam logic [2:0] REG_CTRL    = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned ST_PENDING = 0;
  localparam int unsigned ST_ARMED   = 1;
  localparam int unsigned ST_OVERRUN = 2;

endpackage

// File: rtl/urv_timer_cmp.sv
// Timer alarm/compare unit: 40-bit compare against the core tick count, level
// interrupt, one-shot or auto-reload, plus a tear-free 40-bit time read.
module urv_timer_cmp
  import urv_defs::*;
#(
  parameter int g_with_periodic = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [TIMER_W-1:0]  time_i,
  input  logic [2:0]          addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  input  logic                wr_i,
  input  logic                rd_i,
  output logic                ack_o,
  output logic                irq_o
);

  logic [TIMER_W-1:0] cmp_q, cmp_d;
  logic [31:0]        period_q, period_d;
  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic               irq_en_q, irq_en_d;
  logic               pending_q, pending_d;
  logic               armed_q, armed_d;
  logic               overrun_q, overrun_d;
  logic               hit_q, hit_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [31:0]        data_q, data_d;
  logic               ack_q, ack_d;

  logic wr_cmp;
  logic wr_status;
  logic hit_take;

  assign wr_cmp    = wr_i & ((addr_i == REG_CMP_LO) | (addr_i == REG_CMP_HI));
  assign wr_status = wr_i & (addr_i == REG_STATUS);
  // A compare-register write in the same cycle discards the pending hit entirely.
  assign hit_take  = hit_q & ~wr_cmp;

  always_comb begin
    cmp_d      = cmp_q;
    period_d   = period_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    armed_d    = armed_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    ack_d      = rd_i | wr_i;

    if (hit_take) begin
      if (periodic_q && (period_q != 32'd0)) begin
        cmp_d = cmp_q + {8'b0, period_q};
      end else begin
        armed_d = 1'b0;
      end
    end

    // Hit sets win over a simultaneous write-one-to-clear.
    pending_d = hit_take |
                (pending_q & ~(wr_status & data_i[ST_PENDING]));
    overrun_d = (hit_take & pending_q) |
                (overrun_q & ~(wr_status & data_i[ST_OVERRUN]));

    if (wr_i) begin
      unique case (addr_i)
        REG_CMP_LO: begin
          cmp_d[31:0] = data_i;
          armed_d     = 1'b0;
        end
        REG_CMP_HI: begin
          cmp_d[TIMER_W-1:32] = data_i[7:0];
          armed_d             = 1'b1;
        end
        REG_PERIOD: period_d = data_i;
        REG_CTRL: begin
          en_d       = data_i[CTRL_EN];
          periodic_d = (g_with_periodic != 0) & data_i[CTRL_PERIODIC];
          irq_en_d   = data_i[CTRL_IRQ_EN];
        end
        default: ;
      endcase
    end

    if (rd_i) begin
      unique case (addr_i)
        REG_TIME_LO: begin
          data_d   = time_i[31:0];
          shadow_d = time_i[TIMER_W-1:32];
        end
        REG_TIME_HI: data_d = {24'b0, shadow_q};
        REG_CMP_LO:  data_d = cmp_q[31:0];
        REG_CMP_HI:  data_d = {24'b0, cmp_q[TIMER_W-1:32]};
        REG_PERIOD:  data_d = period_q;
        REG_CTRL:    data_d = {29'b0, irq_en_q, periodic_q, en_q};
        REG_STATUS:  data_d = {29'b0, overrun_q, armed_q, pending_q};
        default:     data_d = 32'b0;
      endcase
    end

    // Compare against the post-edge state so a reload is checked next cycle (catch-up).
    hit_d = en_d & armed_d & (time_i >= cmp_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmp_q      <= '0;
      period_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      armed_q    <= 1'b0;
      overrun_q  <= 1'b0;
      hit_q      <= 1'b0;
      shadow_q   <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      armed_q    <= armed_d;
      overrun_q  <= overrun_d;
      hit_q      <= hit_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
    end
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign irq_o  = pending_q & irq_en_q;

endmodule

// File: tb/tb_urv_timer_cmp.sv
// Directed bench for urv_timer_cmp: bus protocol, shadowed time read,
// one-shot/periodic compare, wrap, and same-cycle event priorities.
module tb_urv_timer_cmp;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic [39:0] time_i = '0;
  logic [2:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        wr_i = 1'b0;
  logic        rd_i = 1'b0;
  logic        ack_o;
  logic        irq_o;

  int n_chk  = 0;
  int n_pass = 0;

  urv_timer_cmp #(.g_with_periodic(1)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .time_i  (time_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .wr_i    (wr_i),
    .rd_i    (rd_i),
    .ack_o   (ack_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic step(input logic [39:0] v);
    @(posedge clk_i); #1;
    time_i = v;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    wr_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    wr_i = 1'b0;
    chk("wr_ack", {39'b0, ack_o}, 40'd1);
  endtask

  task automatic bus_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(posedge clk_i); #1;
    rd_i = 1'b1; addr_i = a;
    #1;
    chk("ack_early", {39'b0, ack_o}, 40'd0);
    @(posedge clk_i); #1;
    rd_i = 1'b0;
    chk("rd_ack", {39'b0, ack_o}, 40'd1);
    chk(tag, {8'b0, data_o}, {8'b0, exp});
  endtask

  task automatic do_reset(input logic [39:0] t);
    time_i  = t;
    rst_n_i = 1'b0;
    cyc(2);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    // reset values and basic read
    #3;
    time_i  = 40'd5;
    rst_n_i = 1'b0;
    cyc(2);
    chk("rst_irq",  {39'b0, irq_o}, 40'd0);
    chk("rst_ack",  {39'b0, ack_o}, 40'd0);
    chk("rst_data", {8'b0, data_o}, 40'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    bus_rd("rst_status", 3'd6, 32'd0);
    bus_rd("time_lo_5", 3'd0, 32'd5);
    cyc(1);
    chk("ack_drop", {39'b0, ack_o}, 40'd0);
    bus_rd("reg7", 3'd7, 32'd0);

    // tear-free time read
    time_i = 40'h12_FFFF_FFFF;
    bus_rd("shadow_lo", 3'd0, 32'hFFFF_FFFF);
    time_i = 40'h13_0000_0000;
    bus_rd("shadow_hi", 3'd1, 32'h12);

    // one-shot
    do_reset(40'd98);
    bus_wr(3'd2, 32'd100);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd5, 32'h5);
    bus_rd("ctrl_rb", 3'd5, 32'h5);
    step(40'd99);
    step(40'd100);
    cyc(1);
    chk("os_irq_n", {39'b0, irq_o}, 40'd0);
    cyc(1);
    chk("os_irq_n1", {39'b0, irq_o}, 40'd1);
    bus_rd("os_status", 3'd6, 32'h1);
    bus_wr(3'd6, 32'h1);
    chk("os_clr_irq", {39'b0, irq_o}, 40'd0);
    step(40'd101);
    step(40'd102);
    step(40'd103);
    cyc(2);
    chk("os_no_refire", {39'b0, irq_o}, 40'd0);
    bus_rd("os_status2", 3'd6, 32'h0);

    // EN gates hits
    bus_wr(3'd5, 32'h4);
    bus_wr(3'd2, 32'd50);
    bus_wr(3'd3, 32'd0);
    cyc(3);
    bus_rd("en_off", 3'd6, 32'h2);
    bus_wr(3'd5, 32'h5);
    cyc(3);
    bus_rd("en_on", 3'd6, 32'h1);

    // periodic with overrun and catch-up
    do_reset(40'd0);
    bus_wr(3'd4, 32'd10);
    bus_wr(3'd2, 32'd100);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd5, 32'h7);
    step(40'd100);
    cyc(1);
    chk("per_irq_n", {39'b0, irq_o}, 40'd0);
    cyc(1);
    chk("per_irq_n1", {39'b0, irq_o}, 40'd1);
    bus_rd("per_st1", 3'd6, 32'h3);
    bus_rd("per_cmp110", 3'd2, 32'd110);
    step(40'd110);
    cyc(3);
    bus_rd("per_ovr", 3'd6, 32'h7);
    bus_wr(3'd6, 32'h5);
    bus_rd("per_clr", 3'd6, 32'h2);
    step(40'd115);
    cyc(2);
    chk("per_115", {39'b0, irq_o}, 40'd0);
    step(40'd135);
    cyc(1);
    chk("cu_hit_q", {39'b0, irq_o}, 40'd0);
    cyc(1);
    chk("cu_first", {39'b0, irq_o}, 40'd1);
    cyc(2);
    bus_rd("cu_status", 3'd6, 32'h7);
    bus_rd("cu_cmp140", 3'd2, 32'd140);

    // reload wraps modulo 2^40
    do_reset(40'hFF_FFFF_FFF0);
    bus_wr(3'd4, 32'd10);
    bus_wr(3'd2, 32'hFFFF_FFFA);
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd5, 32'h7);
    cyc(2);
    chk("wr_pre", {39'b0, irq_o}, 40'd0);
    step(40'hFF_FFFF_FFFA);
    step(40'd0);
    cyc(1);
    chk("wr_hit", {39'b0, irq_o}, 40'd1);
    bus_rd("wr_cmp_lo", 3'd2, 32'd4);
    bus_rd("wr_cmp_hi", 3'd3, 32'd0);
    bus_wr(3'd6, 32'h5);
    bus_rd("wr_clr", 3'd6, 32'h2);
    step(40'd3);
    cyc(2);
    chk("wr_t3", {39'b0, irq_o}, 40'd0);
    step(40'd4);
    cyc(1);
    chk("wr_t4_n", {39'b0, irq_o}, 40'd0);
    cyc(1);
    chk("wr_t4_n1", {39'b0, irq_o}, 40'd1);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst", {39'b0, irq_o}, 40'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc(3);
    bus_rd("post_rst", 3'd6, 32'h0);

    // W1C in the same cycle as a hit: set wins
    do_reset(40'd50);
    bus_wr(3'd2, 32'd60);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd5, 32'h5);
    step(40'd60);
    bus_wr(3'd6, 32'h1);
    bus_rd("w1c_vs_hit", 3'd6, 32'h1);

    // CMP_LO write in the same cycle as a hit: write wins
    do_reset(40'd50);
    bus_wr(3'd2, 32'd60);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd5, 32'h5);
    step(40'd60);
    bus_wr(3'd2, 32'd200);
    cyc(2);
    bus_rd("cmpwr_vs_hit", 3'd6, 32'h0);
    chk("cmpwr_irq", {39'b0, irq_o}, 40'd0);
    bus_rd("cmpwr_val", 3'd2, 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
